// File: rtl/wfg_mem_arbiter.sv
// Two-requester read arbiter for the 1024x32 waveform memory.
// S (streamer) has priority; H (host) is guaranteed service after MAX_STALL refusals.
module wfg_mem_arbiter #(
    parameter int MAX_STALL = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        s_req,
    input  logic [9:0]  s_addr,
    output logic        s_gnt,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    input  logic        h_req,
    input  logic [9:0]  h_addr,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [31:0] h_rdata,
    output logic        csb,
    output logic [9:0]  addr,
    input  logic [31:0] dout
);

    localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    typedef enum logic {
        ID_S = 1'b0,
        ID_H = 1'b1
    } req_id_t;

    logic [SW-1:0] stall_cnt;
    logic          h_wins;
    logic          grant_s;
    logic          grant_h;
    logic          tag_valid;
    req_id_t       tag_id;

    assign h_wins = (MAX_STALL == 0) || (stall_cnt >= STALL_MAX);
    assign s_gnt  = grant_s;
    assign h_gnt  = grant_h;

    // Pick this cycle's winner and drive the memory port; nothing granted in reset.
    always_comb begin
        grant_s = 1'b0;
        grant_h = 1'b0;
        csb     = 1'b1;
        addr    = '0;
        if (!wb_rst_i) begin
            if (s_req && h_req) begin
                grant_h = h_wins;
                grant_s = !h_wins;
            end else begin
                grant_s = s_req;
                grant_h = h_req;
            end
            if (grant_h) begin
                csb  = 1'b0;
                addr = h_addr;
            end else if (grant_s) begin
                csb  = 1'b0;
                addr = s_addr;
            end
        end
    end

    // Count consecutive refusals of H, saturating at the limit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            stall_cnt <= '0;
        end else if (grant_h) begin
            stall_cnt <= '0;
        end else if (h_req && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    // Tag each granted access with its owner so the returning word can be routed.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tag_valid <= 1'b0;
            tag_id    <= ID_S;
        end else begin
            tag_valid <= grant_s || grant_h;
            tag_id    <= grant_h ? ID_H : ID_S;
        end
    end

    // Capture memory data for the tagged requester; the other side holds.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
            s_rdata  <= '0;
            h_rdata  <= '0;
        end else begin
            s_rvalid <= tag_valid && (tag_id == ID_S);
            h_rvalid <= tag_valid && (tag_id == ID_H);
            if (tag_valid && (tag_id == ID_S)) begin
                s_rdata <= dout;
            end
            if (tag_valid && (tag_id == ID_H)) begin
                h_rdata <= dout;
            end
        end
    end

endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// Directed bench for wfg_mem_arbiter: one instance with MAX_STALL=4,
// one with MAX_STALL=0, each with a memory model returning {22'h0, addr}.
module tb_wfg_mem_arbiter;

    logic        clk;
    logic        wb_rst_i;
    logic        s_req;
    logic [9:0]  s_addr;
    logic        h_req;
    logic [9:0]  h_addr;

    logic        s_gnt, h_gnt, s_rvalid, h_rvalid, csb;
    logic [31:0] s_rdata, h_rdata, dout;
    logic [9:0]  addr;

    logic        s_gnt0, h_gnt0, s_rvalid0, h_rvalid0, csb0;
    logic [31:0] s_rdata0, h_rdata0, dout0;
    logic [9:0]  addr0;

    int checks = 0;
    int errors = 0;

    wfg_mem_arbiter #(.MAX_STALL(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .h_req(h_req), .h_addr(h_addr), .h_gnt(h_gnt),
        .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .csb(csb), .addr(addr), .dout(dout)
    );

    wfg_mem_arbiter #(.MAX_STALL(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt0),
        .s_rvalid(s_rvalid0), .s_rdata(s_rdata0),
        .h_req(h_req), .h_addr(h_addr), .h_gnt(h_gnt0),
        .h_rvalid(h_rvalid0), .h_rdata(h_rdata0),
        .csb(csb0), .addr(addr0), .dout(dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        dout  = '0;
        dout0 = '0;
    end

    always @(posedge clk) begin
        if (!csb) dout <= {22'h0, addr};
        if (!csb0) dout0 <= {22'h0, addr0};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_req = 0; h_req = 0; s_addr = '0; h_addr = '0;
        wb_rst_i = 1'b1;
        cyc();
        s_req = 1; h_req = 1;
        @(negedge clk);
        checks++;
        if (csb !== 1'b1 || addr !== 10'h0 || s_gnt !== 1'b0 || h_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_port got csb=%b addr=%h sg=%b hg=%b exp 1 000 0 0",
                     csb, addr, s_gnt, h_gnt);
        end
        checks++;
        if (s_rvalid !== 1'b0 || h_rvalid !== 1'b0 || s_rdata !== 32'h0 || h_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got srv=%b hrv=%b sd=%h hd=%h exp 0 0 0 0",
                     s_rvalid, h_rvalid, s_rdata, h_rdata);
        end
        cyc();
        wb_rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_addr = 10'h0C0 + 10'(k);
            h_addr = 10'h0D0 + 10'(k);
            cyc();
        end
        #2;
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if (csb !== 1'b1 || s_gnt !== 1'b0 || h_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midreset_gnt got csb=%b sg=%b hg=%b exp 1 0 0", csb, s_gnt, h_gnt);
        end
        checks++;
        if (s_rvalid !== 1'b0 || h_rvalid !== 1'b0 || s_rdata !== 32'h0 || h_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_resp got srv=%b hrv=%b sd=%h hd=%h exp 0 0 0 0",
                     s_rvalid, h_rvalid, s_rdata, h_rdata);
        end
        cyc();
        s_req = 0; h_req = 0;
        cyc();
        wb_rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_rvalid !== 1'b0 || h_rvalid !== 1'b0 || s_rdata !== 32'h0 || h_rdata !== 32'h0) begin
                errors++;
                $display("FAIL stale_rvalid k=%0d got srv=%b hrv=%b sd=%h hd=%h exp 0 0 0 0",
                         k, s_rvalid, h_rvalid, s_rdata, h_rdata);
            end
            cyc();
        end
    endtask

    task automatic test_s_only();
        logic [9:0] a [4];
        logic       act;
        logic       rv;
        a[0] = 10'h000; a[1] = 10'h001; a[2] = 10'h200; a[3] = 10'h3FF;
        for (int k = 0; k < 7; k++) begin
            act    = (k < 4);
            s_req  = act;
            s_addr = act ? a[k] : 10'h0;
            h_req  = 0;
            @(negedge clk);
            checks++;
            if (s_gnt !== act || h_gnt !== 1'b0 || csb !== !act
                || addr !== (act ? a[k] : 10'h0)) begin
                errors++;
                $display("FAIL s_only_gnt k=%0d got sg=%b hg=%b csb=%b addr=%h exp %b 0 %b %h",
                         k, s_gnt, h_gnt, csb, addr, act, !act, act ? a[k] : 10'h0);
            end
            rv = (k >= 2) && (k < 6);
            checks++;
            if (s_rvalid !== rv || h_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL s_only_rvalid k=%0d got srv=%b hrv=%b exp %b 0",
                         k, s_rvalid, h_rvalid, rv);
            end
            if (rv) begin
                checks++;
                if (s_rdata !== {22'h0, a[k-2]}) begin
                    errors++;
                    $display("FAIL s_only_rdata k=%0d got %h exp %h",
                             k, s_rdata, {22'h0, a[k-2]});
                end
            end
            cyc();
        end
    endtask

    task automatic test_starvation();
        logic act;
        logic eh;
        logic ph;
        for (int k = 0; k < 12; k++) begin
            act    = (k < 10);
            s_req  = act;
            h_req  = act;
            s_addr = 10'h0AA;
            h_addr = 10'h155;
            eh     = act && ((k % 5) == 4);
            @(negedge clk);
            checks++;
            if (h_gnt !== eh || s_gnt !== (act && !eh)) begin
                errors++;
                $display("FAIL starve_gnt k=%0d got sg=%b hg=%b exp %b %b",
                         k, s_gnt, h_gnt, act && !eh, eh);
            end
            checks++;
            if (h_gnt0 !== act || s_gnt0 !== 1'b0 || addr0 !== (act ? 10'h155 : 10'h0)) begin
                errors++;
                $display("FAIL strict_gnt k=%0d got sg=%b hg=%b addr=%h exp 0 %b %h",
                         k, s_gnt0, h_gnt0, addr0, act, act ? 10'h155 : 10'h0);
            end
            if (k >= 2) begin
                ph = (((k - 2) % 5) == 4);
                checks++;
                if (h_rvalid !== ph || s_rvalid !== !ph) begin
                    errors++;
                    $display("FAIL starve_rvalid k=%0d got srv=%b hrv=%b exp %b %b",
                             k, s_rvalid, h_rvalid, !ph, ph);
                end
                checks++;
                if ((ph && h_rdata !== 32'h155) || (!ph && s_rdata !== 32'h0AA)) begin
                    errors++;
                    $display("FAIL starve_rdata k=%0d got sd=%h hd=%h exp %s",
                             k, s_rdata, h_rdata, ph ? "hd=155" : "sd=0aa");
                end
            end
            cyc();
        end
        s_req = 0; h_req = 0;
        cyc();
    endtask

    task automatic test_interleave();
        logic        tsr [6] = '{1, 0, 1, 0, 0, 0};
        logic        thr [6] = '{0, 1, 0, 0, 0, 0};
        logic [9:0]  tad [6] = '{10'h010, 10'h205, 10'h011, 10'h0, 10'h0, 10'h0};
        logic        esv [6] = '{0, 0, 1, 0, 1, 0};
        logic        ehv [6] = '{0, 0, 0, 1, 0, 0};
        logic [31:0] esd [6] = '{32'h0AA, 32'h0AA, 32'h010, 32'h010, 32'h011, 32'h011};
        logic [31:0] ehd [6] = '{32'h155, 32'h155, 32'h155, 32'h205, 32'h205, 32'h205};
        for (int k = 0; k < 6; k++) begin
            s_req  = tsr[k];
            h_req  = thr[k];
            s_addr = tsr[k] ? tad[k] : 10'h0;
            h_addr = thr[k] ? tad[k] : 10'h0;
            @(negedge clk);
            checks++;
            if (s_gnt !== tsr[k] || h_gnt !== thr[k]
                || addr !== ((tsr[k] || thr[k]) ? tad[k] : 10'h0)) begin
                errors++;
                $display("FAIL ilv_gnt k=%0d got sg=%b hg=%b addr=%h exp %b %b %h",
                         k, s_gnt, h_gnt, addr, tsr[k], thr[k], tad[k]);
            end
            checks++;
            if (s_rvalid !== esv[k] || h_rvalid !== ehv[k]) begin
                errors++;
                $display("FAIL ilv_rvalid k=%0d got srv=%b hrv=%b exp %b %b",
                         k, s_rvalid, h_rvalid, esv[k], ehv[k]);
            end
            checks++;
            if (s_rdata !== esd[k] || h_rdata !== ehd[k]) begin
                errors++;
                $display("FAIL ilv_rdata k=%0d got sd=%h hd=%h exp %h %h",
                         k, s_rdata, h_rdata, esd[k], ehd[k]);
            end
            cyc();
        end
    endtask

    task automatic test_idle();
        s_req = 0; h_req = 0; s_addr = 10'h3AB; h_addr = 10'h1CD;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (csb !== 1'b1 || addr !== 10'h0 || s_gnt !== 1'b0 || h_gnt !== 1'b0) begin
                errors++;
                $display("FAIL idle_port k=%0d got csb=%b addr=%h sg=%b hg=%b exp 1 000 0 0",
                         k, csb, addr, s_gnt, h_gnt);
            end
            checks++;
            if (s_rvalid !== 1'b0 || h_rvalid !== 1'b0
                || s_rdata !== 32'h011 || h_rdata !== 32'h205) begin
                errors++;
                $display("FAIL idle_resp k=%0d got srv=%b hrv=%b sd=%h hd=%h exp 0 0 011 205",
                         k, s_rvalid, h_rvalid, s_rdata, h_rdata);
            end
            cyc();
        end
    endtask

    initial begin
        wb_rst_i = 1'b0;
        s_req = 0; h_req = 0; s_addr = '0; h_addr = '0;
        #1;
        test_reset();
        test_s_only();
        test_starvation();
        test_interleave();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
